// File: rtl/and_nand_or_nor_if.sv
// +----------------------------------------------------------------------------+
// | Module   : and_nand_or_nor_if                                              |
// | Purpose  : Bundles the operand side and the result side of the registered  |
// |            AND/NAND/OR/NOR unit into one connection.                       |
// | Signals  : in_valid   operands valid this cycle          (master -> slave) |
// |            in0, in1   WIDTH-bit operands                 (master -> slave) |
// |            out_valid  registered in_valid                (slave -> master) |
// |            and_out    in0 & in1                          (slave -> master) |
// |            nand_out   ~(in0 & in1)                       (slave -> master) |
// |            or_out     in0 | in1                          (slave -> master) |
// |            nor_out    ~(in0 | in1)                       (slave -> master) |
// | Modports : master - upstream/downstream logic around the unit              |
// |            slave  - the logic unit itself                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface and_nand_or_nor_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;

    logic             out_valid;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] nand_out;
    logic [WIDTH-1:0] or_out;
    logic [WIDTH-1:0] nor_out;

    // The master both supplies operands and samples the results.
    modport master (
        output in_valid,
        output in0,
        output in1,
        input  out_valid,
        input  and_out,
        input  nand_out,
        input  or_out,
        input  nor_out
    );

    modport slave (
        input  in_valid,
        input  in0,
        input  in1,
        output out_valid,
        output and_out,
        output nand_out,
        output or_out,
        output nor_out
    );
endinterface

`default_nettype wire

// File: rtl/and_nand_or_nor.sv
// +----------------------------------------------------------------------------+
// | Module   : and_nand_or_nor                                                 |
// | Purpose  : Registered two-input bitwise logic unit producing AND, NAND, OR |
// |            and NOR of two operands with a valid qualifier and exactly one  |
// |            clock of latency. No backpressure: one operand pair may be      |
// |            accepted every cycle.                                           |
// | Params   : WIDTH  operand/result width in bits (>= 1)                      |
// | Ports    : clk    rising-edge clock for all state                          |
// |            rst_n  synchronous active-low reset                             |
// |            bus    and_nand_or_nor_if.slave (operands in, results out)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module and_nand_or_nor #(
    parameter int WIDTH = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    and_nand_or_nor_if.slave    bus
);

    // Reset image is the truth-table row for in0 = in1 = 0, so the outputs
    // are mutually consistent even before the first valid operand arrives.
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONES = '1;

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] and_q;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] nand_q;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] or_q;
    logic [WIDTH-1:0] or_d;
    logic [WIDTH-1:0] nor_q;
    logic [WIDTH-1:0] nor_d;

    // Next-state: results only load on a valid cycle; otherwise they hold,
    // so downstream logic can keep reading the last result after out_valid
    // drops. out_valid is simply in_valid delayed by one clock.
    always_comb begin
        valid_d = bus.in_valid;
        and_d   = and_q;
        nand_d  = nand_q;
        or_d    = or_q;
        nor_d   = nor_q;
        if (bus.in_valid) begin
            and_d  = bus.in0 & bus.in1;
            nand_d = ~(bus.in0 & bus.in1);
            or_d   = bus.in0 | bus.in1;
            nor_d  = ~(bus.in0 | bus.in1);
        end
    end

    // Reset wins over in_valid: an operand pair presented during reset is
    // dropped and never produces a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            and_q   <= C_ZERO;
            nand_q  <= C_ONES;
            or_q    <= C_ZERO;
            nor_q   <= C_ONES;
        end else begin
            valid_q <= valid_d;
            and_q   <= and_d;
            nand_q  <= nand_d;
            or_q    <= or_d;
            nor_q   <= nor_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.and_out   = and_q;
    assign bus.nand_out  = nand_q;
    assign bus.or_out    = or_q;
    assign bus.nor_out   = nor_q;

endmodule

`default_nettype wire

// File: tb/tb_and_nand_or_nor.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_and_nand_or_nor                                              |
// | Purpose  : Self-checking bench for and_nand_or_nor at WIDTH=1 and WIDTH=8. |
// |            Expected results are queued when operands are driven and       |
// |            popped when the unit raises out_valid.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_and_nand_or_nor;

    logic clk;
    logic rst_n1;
    logic rst_n8;

    and_nand_or_nor_if #(.WIDTH(1)) b1 ();
    and_nand_or_nor_if #(.WIDTH(8)) b8 ();

    and_nand_or_nor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (b1.slave)
    );

    and_nand_or_nor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .bus   (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Scoreboard entry for the 8-bit unit: {and, nand, or, nor}.
    logic [31:0] sb[$];
    // Result the 8-bit unit should be holding when no new result appears.
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold8(input logic [7:0] a, input logic [7:0] b);
        return {a & b, ~(a & b), a | b, ~(a | b)};
    endfunction

    task automatic check_inv8(input string tag);
        chk({tag, "_inv_nand"}, {24'h0, b8.nand_out}, {24'h0, ~b8.and_out});
        chk({tag, "_inv_nor"},  {24'h0, b8.nor_out},  {24'h0, ~b8.or_out});
        chk({tag, "_inv_and_or"}, {24'h0, b8.and_out & ~b8.or_out}, 32'h0);
    endtask

    // One clock of stimulus on the 8-bit unit, then check after the edge.
    task automatic step8(input string tag, input logic rst, input logic vld,
                         input logic [7:0] a, input logic [7:0] b);
        logic [31:0] obs;
        logic [31:0] exp;
        @(negedge clk);
        rst_n8      = rst;
        b8.in_valid = vld;
        b8.in0      = a;
        b8.in1      = b;
        if (rst && vld) sb.push_back(gold8(a, b));
        @(posedge clk);
        #1;
        obs = {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out};
        chk({tag, "_valid"}, {31'h0, b8.out_valid}, {31'h0, rst && vld});
        if (b8.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_spurious"}, 32'd0, 32'd1);
            end else begin
                exp  = sb.pop_front();
                held = exp;
                chk({tag, "_result"}, obs, exp);
            end
        end else begin
            if (!rst) held = 32'h00FF00FF;
            chk({tag, "_hold"}, obs, held);
        end
        check_inv8(tag);
    endtask

    logic [3:0] tt1 [4];

    initial begin
        tt1[0] = 4'b0101;
        tt1[1] = 4'b0110;
        tt1[2] = 4'b0110;
        tt1[3] = 4'b1010;
        held   = 32'h00FF00FF;

        rst_n1 = 1'b0;
        rst_n8 = 1'b0;
        b1.in_valid = 1'b0; b1.in0 = 1'b0; b1.in1 = 1'b0;
        b8.in_valid = 1'b0; b8.in0 = 8'h00; b8.in1 = 8'h00;

        // WIDTH=1 reset values.
        @(posedge clk);
        #1;
        chk("w1_rst_valid", {31'h0, b1.out_valid}, 32'd0);
        chk("w1_rst_res", {28'h0, b1.and_out, b1.nand_out, b1.or_out, b1.nor_out}, 32'b0101);

        // WIDTH=1 full truth table back to back.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n1      = 1'b1;
            b1.in_valid = 1'b1;
            b1.in0      = i[0];
            b1.in1      = i[1];
            @(posedge clk);
            #1;
            chk($sformatf("w1_tt%0d_valid", i), {31'h0, b1.out_valid}, 32'd1);
            chk($sformatf("w1_tt%0d_res", i),
                {28'h0, b1.and_out, b1.nand_out, b1.or_out, b1.nor_out}, {28'h0, tt1[i]});
        end
        @(negedge clk);
        b1.in_valid = 1'b0;

        // WIDTH=8 reset state.
        @(posedge clk);
        #1;
        chk("w8_rst_valid", {31'h0, b8.out_valid}, 32'd0);
        chk("w8_rst_res", {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out}, 32'h00FF00FF);

        // Directed operand pair with fixed expected values.
        step8("w8_f0cc", 1'b1, 1'b1, 8'hF0, 8'hCC);
        chk("w8_f0cc_const", {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out}, 32'hC03FFC03);

        // in_valid low with new operands: results must hold.
        step8("w8_hold", 1'b1, 1'b0, 8'h00, 8'hFF);
        chk("w8_hold_const", {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out}, 32'hC03FFC03);

        // Reset beats in_valid; the dropped valid never appears.
        step8("w8_rstv", 1'b0, 1'b1, 8'hFF, 8'hFF);
        chk("w8_rstv_const", {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out}, 32'h00FF00FF);
        step8("w8_post", 1'b1, 1'b0, 8'hFF, 8'hFF);
        chk("w8_post_const", {b8.and_out, b8.nand_out, b8.or_out, b8.nor_out}, 32'h00FF00FF);

        // Back-to-back valids then a random stream with occasional reset.
        step8("w8_b2b0", 1'b1, 1'b1, 8'hAA, 8'h55);
        step8("w8_b2b1", 1'b1, 1'b1, 8'hFF, 8'h0F);
        for (int n = 0; n < 1000; n++) begin
            step8("w8_rand",
                  ($urandom_range(31) != 0),
                  ($urandom_range(3) != 0),
                  8'($urandom),
                  8'($urandom));
        end

        chk("w8_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
